// File: rtl/ifu_pkg.sv
// Shared types, constants and helpers for the instruction fetch unit.
// Latency: not applicable (package only).
// Backpressure: not applicable (package only).
package ifu_pkg;

  localparam int INSTR_W    = 32;
  localparam int ENTRY_PC_W = 64;

  // Opcode field value in bits [31:21] that marks the HALT word.
  localparam logic [10:0] HALT_OPC = 11'h7FF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } ifu_state_e;

  // One prefetch queue entry; pc is sized for the widest supported PC and
  // zero-extended by the fetch unit.
  typedef struct packed {
    logic [ENTRY_PC_W-1:0] pc;
    logic [INSTR_W-1:0]    instr;
  } ifu_entry_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return (word >> 21) == INSTR_W'(HALT_OPC);
  endfunction

endpackage

// File: rtl/ifu_queue.sv
// Generic synchronous FIFO with flush; registered storage, head visible combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: full_o signals no room; push while full is legal only with a same-cycle pop.
module ifu_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign count_o   = cnt_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; a flush discards every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // A push into a full queue without a pop means the producer ignored its credits.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push_i && full_o && !do_pop && !flush_i));
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues IMem word requests, queues {pc,instr}, hands them to decode; optional IFU_PERF_CNT_EN adds perf counters.
// Latency: a response is offered to decode the cycle after it returns; redirect takes effect on the next cycle.
// Backpressure: decode stalls via id_ready; requests are credit-limited by queue room and MAX_OUTST.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              PC_W      = 64,
  parameter int              ADDR_W    = 12,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [PC_W-1:0]   id_pc,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushes
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_e      state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            stop_fetch_q, stop_fetch_d;
  logic            active_q;

  ifu_entry_t      push_entry;
  ifu_entry_t      head_entry;
  logic [PC_W-1:0] rsp_pc;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   outst_next;
  logic [CW:0]     credit_used;
  logic            q_empty, q_full, pcq_empty, pcq_full;
  logic            req_fire, pop_fire, halt_pop, q_flush, q_push, rsp_drop;
  logic            unused_ok;

  assign credit_used    = {1'b0, q_count} + {1'b0, outst};
  assign imem_req_valid = active_q && (state_q == ST_RUN) && !stop_fetch_q &&
                          (outst < CW'(MAX_OUTST)) && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = {fetch_pc_q[ADDR_W-1:2], 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign outst_next     = outst + CW'(req_fire) - CW'(imem_rsp_valid);

  assign id_valid = !q_empty;
  assign id_instr = q_empty ? '0 : head_entry.instr;
  assign id_pc    = q_empty ? '0 : head_entry.pc[PC_W-1:0];
  assign halted   = (state_q == ST_HALTED);

  // Redirect wins over a pop; a popped HALT flushes whatever followed it.
  assign pop_fire = id_valid && id_ready && !redirect_valid;
  assign halt_pop = pop_fire && is_halt(head_entry.instr);
  assign q_flush  = redirect_valid || halt_pop;
  assign rsp_drop = redirect_valid || halt_pop || (drop_cnt_q != '0) || (state_q == ST_HALTED);
  assign q_push   = imem_rsp_valid && !rsp_drop;

  assign unused_ok = ^{q_full, pcq_full, head_entry.pc};

  // Zero-extend the response PC into the shared entry layout.
  always_comb begin
    push_entry                = '0;
    push_entry.pc[PC_W-1:0]   = rsp_pc;
    push_entry.instr          = imem_rsp_data;
  end

  // PC of every in-flight request, popped in order as responses return;
  // its occupancy is the outstanding-request count.
  ifu_queue #(
    .WIDTH (PC_W),
    .DEPTH (DEPTH)
  ) u_pc_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (1'b0),
    .push_i     (req_fire),
    .push_dat_i (fetch_pc_q),
    .pop_i      (imem_rsp_valid),
    .pop_dat_o  (rsp_pc),
    .count_o    (outst),
    .empty_o    (pcq_empty),
    .full_o     (pcq_full)
  );

  // Prefetch queue feeding decode.
  ifu_queue #(
    .WIDTH ($bits(ifu_entry_t)),
    .DEPTH (DEPTH)
  ) u_prefetch_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (q_flush),
    .push_i     (q_push),
    .push_dat_i (push_entry),
    .pop_i      (pop_fire),
    .pop_dat_o  (head_entry),
    .count_o    (q_count),
    .empty_o    (q_empty),
    .full_o     (q_full)
  );

  // Next-state: PC advance, drop accounting, HALT stop and redirect override.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drop_cnt_d   = drop_cnt_q;
    stop_fetch_d = stop_fetch_q;

    if (req_fire) fetch_pc_d = fetch_pc_q + PC_W'(4);
    if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    if (q_push && is_halt(imem_rsp_data)) stop_fetch_d = 1'b1;

    case (state_q)
      ST_RUN: begin
        // Anything still in flight after HALT belongs to the dead path.
        if (halt_pop) begin
          state_d    = ST_HALTED;
          drop_cnt_d = outst_next;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
    endcase

    // Every request still in flight after this cycle is on the old path.
    if (redirect_valid) begin
      state_d      = ST_RUN;
      fetch_pc_d   = redirect_pc & ~PC_W'(3);
      drop_cnt_d   = outst_next;
      stop_fetch_d = 1'b0;
    end
  end

  // State register; active_q holds off requests until the first cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      fetch_pc_q   <= RESET_PC;
      drop_cnt_q   <= '0;
      stop_fetch_q <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drop_cnt_q   <= drop_cnt_d;
      stop_fetch_q <= stop_fetch_d;
      active_q     <= 1'b1;
    end
  end

  // Responses are in order and only ever answer an issued request.
  always_ff @(posedge clk) begin
    if (rst_n && imem_rsp_valid) assert (!pcq_empty);
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushes_q;

  // Saturating counts of words delivered to decode and redirects taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (pop_fire && (perf_fetched_q != '1))       perf_fetched_q <= perf_fetched_q + 32'd1;
      if (redirect_valid && (perf_flushes_q != '1)) perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency in-order IMem model.
// Latency: memory latency is set per scenario through lat.
// Backpressure: decode readiness is driven directly by the stimulus.
module tb_instr_fetch_unit;

  localparam int PC_W   = 64;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_req_valid;
  logic              imem_req_ready = 1'b1;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid = 1'b0;
  logic [31:0]       imem_rsp_data = '0;
  logic              id_valid;
  logic              id_ready = 1'b1;
  logic [31:0]       id_instr;
  logic [PC_W-1:0]   id_pc;
  logic              redirect_valid = 1'b0;
  logic [PC_W-1:0]   redirect_pc = '0;
  logic              halted;
`ifdef IFU_PERF_CNT_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_flushes;
`endif

  instr_fetch_unit #(
    .PC_W      (PC_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (4),
    .MAX_OUTST (2),
    .RESET_PC  ('0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem [4096];
  int          cyc = 0;
  int          lat = 1;
  int          pend_due[$];
  logic [11:0] pend_addr[$];
  logic [11:0] rsp_a;
  logic [11:0] req_log[$];
  logic [63:0] pop_pc_log[$];
  logic [31:0] pop_ins_log[$];
  logic        halt_rsp_seen = 1'b0;
  int          late_reqs = 0;
  int          pbase;
  int          rbase;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] prog_word(input int idx);
    case (idx)
      0:       return 32'h8B020020;
      1:       return 32'h91000421;
      2:       return 32'hD1000442;
      3:       return 32'hAA0103E3;
      4:       return 32'hFFE00000;
      default: return 32'h10000000 | 32'(idx);
    endcase
  endfunction

  function automatic logic [63:0] pop_pc_at(input int i);
    if (i < pop_pc_log.size()) return pop_pc_log[i];
    return '1;
  endfunction

  function automatic logic [63:0] pop_ins_at(input int i);
    if (i < pop_ins_log.size()) return 64'(pop_ins_log[i]);
    return '1;
  endfunction

  function automatic logic [63:0] req_at(input int i);
    if (i < req_log.size()) return 64'(req_log[i]);
    return '1;
  endfunction

  // Memory model: accept at posedge, present the response at the negedge once due.
  always @(posedge clk) begin
    if (!rst_n) begin
      pend_due.delete();
      pend_addr.delete();
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        pend_due.push_back(cyc + lat);
        pend_addr.push_back(imem_req_addr);
        if (!redirect_valid) req_log.push_back(imem_req_addr);
        if (halt_rsp_seen) late_reqs++;
      end
      if (imem_rsp_valid && (imem_rsp_data[31:21] == 11'h7FF)) halt_rsp_seen = 1'b1;
      if (id_valid && id_ready && !redirect_valid) begin
        pop_pc_log.push_back(id_pc);
        pop_ins_log.push_back(id_instr);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rst_n && (pend_due.size() > 0) && (pend_due[0] <= cyc)) begin
      rsp_a = pend_addr.pop_front();
      void'(pend_due.pop_front());
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = {mem[rsp_a + 12'd3], mem[rsp_a + 12'd2], mem[rsp_a + 12'd1], mem[rsp_a]};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pops(input int base, input int n, input int budget);
    for (int k = 0; k < budget && (pop_pc_log.size() < base + n); k++) tick();
  endtask

  task automatic wait_pend2(input string tag);
    for (int k = 0; k < 30 && (pend_addr.size() != 2); k++) tick();
    check_val(tag, 64'(pend_addr.size()), 64'd2);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    check_val({tag, "_id_valid"},  64'(id_valid),       64'd0);
    check_val({tag, "_id_instr"},  64'(id_instr),       64'd0);
    check_val({tag, "_id_pc"},     id_pc,               64'd0);
    check_val({tag, "_halted"},    64'(halted),         64'd0);
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 1024; i++) begin
      w = prog_word(i);
      mem[4*i]   = w[7:0];
      mem[4*i+1] = w[15:8];
      mem[4*i+2] = w[23:16];
      mem[4*i+3] = w[31:24];
    end

    // Reset values while held in reset.
    repeat (3) tick();
    check_reset_outs("rst");

    // Straight-line fetch, 1-cycle memory, decode always ready, HALT at 0x10.
    pbase = pop_pc_log.size();
    rst_n = 1'b1;
    wait_pops(pbase, 5, 80);
    check_val("seq_pc0",    pop_pc_at(pbase),     64'h0);
    check_val("seq_ins0",   pop_ins_at(pbase),    64'h8B020020);
    check_val("seq_pc1",    pop_pc_at(pbase + 1), 64'h4);
    check_val("seq_ins1",   pop_ins_at(pbase + 1), 64'h91000421);
    check_val("seq_pc2",    pop_pc_at(pbase + 2), 64'h8);
    check_val("seq_ins2",   pop_ins_at(pbase + 2), 64'hD1000442);
    check_val("seq_pc3",    pop_pc_at(pbase + 3), 64'hC);
    check_val("seq_ins3",   pop_ins_at(pbase + 3), 64'hAA0103E3);
    check_val("halt_pc",    pop_pc_at(pbase + 4), 64'h10);
    check_val("halt_ins",   pop_ins_at(pbase + 4), 64'hFFE00000);
    repeat (6) tick();
    check_val("halt_halted",    64'(halted),                      64'd1);
    check_val("halt_id_valid",  64'(id_valid),                    64'd0);
    check_val("halt_req_valid", 64'(imem_req_valid),              64'd0);
    check_val("halt_pop_count", 64'(pop_pc_log.size() - pbase),   64'd5);
    check_val("halt_late_reqs", 64'(late_reqs),                   64'd0);

    // Resume from HALTED with decode stalled: queue fills to DEPTH and holds.
    id_ready = 1'b0;
    rbase = req_log.size();
    do_redirect(64'h0);
    check_val("resume_halted", 64'(halted), 64'd0);
    repeat (10) tick();
    check_val("stall_req_count", 64'(req_log.size() - rbase), 64'd4);
    check_val("stall_req_valid", 64'(imem_req_valid),         64'd0);
    check_val("stall_id_valid",  64'(id_valid),               64'd1);
    for (int k = 0; k < 3; k++) begin
      check_val("stall_id_pc",    id_pc,            64'h0);
      check_val("stall_id_instr", 64'(id_instr),    64'h8B020020);
      tick();
    end
    pbase = pop_pc_log.size();
    id_ready = 1'b1;
    wait_pops(pbase, 5, 60);
    check_val("release_pc0", pop_pc_at(pbase),     64'h0);
    check_val("release_pc1", pop_pc_at(pbase + 1), 64'h4);
    check_val("release_pc2", pop_pc_at(pbase + 2), 64'h8);
    check_val("release_pc3", pop_pc_at(pbase + 3), 64'hC);
    check_val("release_pc4", pop_pc_at(pbase + 4), 64'h10);
    repeat (6) tick();
    check_val("release_halted", 64'(halted), 64'd1);

    // Redirect to 0x40 with two requests in flight on a 3-cycle memory.
    lat = 3;
    do_redirect(64'h20);
    wait_pend2("flight_two_pending");
    pbase = pop_pc_log.size();
    rbase = req_log.size();
    do_redirect(64'h40);
    check_val("flight_id_valid_after", 64'(id_valid), 64'd0);
    wait_pops(pbase, 2, 60);
    check_val("flight_first_req", req_at(rbase),        64'h40);
    check_val("flight_pc0",       pop_pc_at(pbase),     64'h40);
    check_val("flight_ins0",      pop_ins_at(pbase),    64'h10000010);
    check_val("flight_pc1",       pop_pc_at(pbase + 1), 64'h44);
    check_val("flight_ins1",      pop_ins_at(pbase + 1), 64'h10000011);

    // Unaligned redirect target is word-aligned.
    lat = 1;
    repeat (2) tick();
    pbase = pop_pc_log.size();
    rbase = req_log.size();
    do_redirect(64'h42);
    wait_pops(pbase, 1, 40);
    check_val("unal_req_addr", req_at(rbase),     64'h40);
    check_val("unal_pc",       pop_pc_at(pbase),  64'h40);
    check_val("unal_ins",      pop_ins_at(pbase), 64'h10000010);

    // Reset mid-stream with two requests outstanding.
    lat = 3;
    wait_pend2("mid_two_pending");
    rst_n = 1'b0;
    #1;
    check_reset_outs("mid_rst");
    repeat (2) tick();
    lat = 1;
    pbase = pop_pc_log.size();
    rst_n = 1'b1;
    wait_pops(pbase, 2, 40);
    check_val("post_rst_pc0",  pop_pc_at(pbase),      64'h0);
    check_val("post_rst_ins0", pop_ins_at(pbase),     64'h8B020020);
    check_val("post_rst_pc1",  pop_pc_at(pbase + 1),  64'h4);
    check_val("post_rst_ins1", pop_ins_at(pbase + 1), 64'h91000421);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
